// File: rtl/mu_access_ctrl_pkg.sv
// Shared memory-system constants and types for the memory access controller.
package mu_access_ctrl_pkg;

  localparam int unsigned MEM_DATA_WIDTH = 32;
  localparam int unsigned MEM_ADDR_WIDTH = 64;
  localparam int unsigned MEM_IDX_W      = $clog2(MEM_ADDR_WIDTH);

  localparam logic [31:0] MEM_ROM_BASE = 32'h0040_0000;
  localparam logic [31:0] MEM_RAM_BASE = 32'h1001_0000;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWrite,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_NONE
  } region_e;

endpackage

// File: rtl/mu_addr_decode.sv
// Byte address decode into ROM/RAM word index; flags misaligned, unmapped and ROM stores.
module mu_addr_decode
  import mu_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter logic [31:0] ROM_BASE   = MEM_ROM_BASE,
  parameter logic [31:0] RAM_BASE   = MEM_RAM_BASE,
  parameter int unsigned IDX_W      = $clog2(ADDR_WIDTH)
) (
  input  logic [31:0]      addr,
  input  logic             we,
  output region_e          region,
  output logic [IDX_W-1:0] idx,
  output logic             err
);

  // 33-bit compare so a base near the top of the address space cannot wrap.
  localparam logic [32:0] SPAN = 33'(4 * ADDR_WIDTH);

  logic rom_hit, ram_hit, misaligned;

  always_comb begin
    rom_hit    = ({1'b0, addr} >= {1'b0, ROM_BASE}) && ({1'b0, addr} < {1'b0, ROM_BASE} + SPAN);
    ram_hit    = ({1'b0, addr} >= {1'b0, RAM_BASE}) && ({1'b0, addr} < {1'b0, RAM_BASE} + SPAN);
    misaligned = (addr[1:0] != 2'b00);
    region     = REG_NONE;
    idx        = '0;
    if (rom_hit) begin
      region = REG_ROM;
      idx    = IDX_W'((addr - ROM_BASE) >> 2);
    end else if (ram_hit) begin
      region = REG_RAM;
      idx    = IDX_W'((addr - RAM_BASE) >> 2);
    end
    err = misaligned || (region == REG_NONE) || ((region == REG_ROM) && we);
  end

endmodule

// File: rtl/mu_access_ctrl.sv
// Single-outstanding memory access controller: decodes requests, sequences ROM/RAM
// reads and writes, and returns a response through a valid/ready handshake.
module mu_access_ctrl
  import mu_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter logic [31:0] ROM_BASE   = MEM_ROM_BASE,
  parameter logic [31:0] RAM_BASE   = MEM_RAM_BASE,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned IDX_W      = $clog2(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [IDX_W-1:0]      rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic [IDX_W-1:0]      ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

  state_e                state_q, state_d;
  region_e               region_q, dec_region;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  accept;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, ram_wdata_q;
  logic                  rsp_err_q;
  logic [IDX_W-1:0]      rom_addr_q, ram_addr_q;

  mu_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROM_BASE   (ROM_BASE),
    .RAM_BASE   (RAM_BASE),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr   (req_addr),
    .we     (req_we),
    .region (dec_region),
    .idx    (dec_idx),
    .err    (dec_err)
  );

  assign accept = req_valid && (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (dec_err)     state_d = StResp;
          else if (req_we) state_d = StWrite;
          else             state_d = StRdWait;
        end
      end
      StRdWait: if (cnt_q == '0) state_d = StResp;
      StWrite:  state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Faulting requests only update the response; memory-facing registers keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q    <= REG_NONE;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rom_addr_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else if (accept) begin
      region_q    <= dec_region;
      cnt_q       <= CNT_INIT;
      rsp_rdata_q <= '0;
      rsp_err_q   <= dec_err;
      if (!dec_err) begin
        if (dec_region == REG_ROM) rom_addr_q <= dec_idx;
        else                       ram_addr_q <= dec_idx;
        if (req_we) ram_wdata_q <= req_wdata;
      end
    end else if (state_q == StRdWait) begin
      if (cnt_q == '0) rsp_rdata_q <= (region_q == REG_ROM) ? rom_rdata : ram_rdata;
      else             cnt_q       <= cnt_q - CNT_W'(1);
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign ram_we    = (state_q == StWrite);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rom_addr  = rom_addr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mu_access_ctrl.sv
// Scoreboard bench for mu_access_ctrl with behavioural ROM/RAM models.
module tb_mu_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [5:0]  rom_addr, ram_addr;
  logic [31:0] rom_rdata, ram_rdata, ram_wdata;
  logic        ram_we;

  logic [31:0] rom [64];
  logic [31:0] ram [64];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int we_pulses = 0;

  always #5 clk = ~clk;

  mu_access_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  assign rom_rdata = rom[rom_addr];
  assign ram_rdata = ram[ram_addr];

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      we_pulses++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed response handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=%0h required=none", rsp_rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
        chk("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
      end
    end
  end

  // Returns #1 after the accepting edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input bit push,
                      input bit keep);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end
    if (push) sb_q.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  logic [31:0] err_addr [3];
  logic        err_we   [3];

  initial begin
    int n;
    int we_before;
    bit saw_valid;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rom[i] = 32'h1000_0000 + i;
      ram[i] = '0;
    end
    rom[2] = 32'h2008_0005;
    err_addr[0] = 32'h1001_0002; err_we[0] = 1'b0;
    err_addr[1] = 32'h1001_0100; err_we[1] = 1'b0;
    err_addr[2] = 32'h0040_0000; err_we[2] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'h0, req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'd0);
    chk("rst_rsp_err", {63'h0, rsp_err}, 64'd0);
    chk("rst_rsp_rdata", {32'h0, rsp_rdata}, 64'd0);
    chk("rst_rom_addr", {58'h0, rom_addr}, 64'd0);
    chk("rst_ram_addr", {58'h0, ram_addr}, 64'd0);
    chk("rst_ram_we", {63'h0, ram_we}, 64'd0);
    chk("rst_ram_wdata", {32'h0, ram_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ROM load with latency 1: response two cycles after acceptance.
    send(1'b0, 32'h0040_0008, '0, 32'h2008_0005, 1'b0, 1'b1, 1'b0);
    chk("load_rom_addr", {58'h0, rom_addr}, 64'd2);
    chk("load_not_early", {63'h0, rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("load_rsp_valid", {63'h0, rsp_valid}, 64'd1);

    // RAM store to top word, then read back.
    we_before = we_pulses;
    send(1'b1, 32'h1001_00FC, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("store_ram_we", {63'h0, ram_we}, 64'd1);
    chk("store_ram_addr", {58'h0, ram_addr}, 64'd63);
    chk("store_ram_wdata", {32'h0, ram_wdata}, 64'hDEAD_BEEF);
    @(posedge clk);
    #1;
    chk("store_we_drop", {63'h0, ram_we}, 64'd0);
    chk("store_rsp_valid", {63'h0, rsp_valid}, 64'd1);
    chk("store_we_pulses", 64'(we_pulses - we_before), 64'd1);
    send(1'b0, 32'h1001_00FC, '0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);

    // Faulting accesses respond next cycle and never strobe the RAM.
    we_before = we_pulses;
    for (int i = 0; i < 3; i++) begin
      send(err_we[i], err_addr[i], 32'h5555_AAAA, 32'h0, 1'b1, 1'b1, 1'b0);
      chk("err_rsp_valid", {63'h0, rsp_valid}, 64'd1);
      chk("err_rsp_err", {63'h0, rsp_err}, 64'd1);
      chk("err_ram_we", {63'h0, ram_we}, 64'd0);
    end
    @(posedge clk);
    #1;
    chk("err_we_pulses", 64'(we_pulses - we_before), 64'd0);

    // Backpressure: response held while rsp_ready is low.
    @(negedge clk);
    rsp_ready = 1'b0;
    send(1'b0, 32'h0040_000C, '0, 32'h1000_0003, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", {63'h0, rsp_valid}, 64'd1);
      chk("bp_rsp_rdata", {32'h0, rsp_rdata}, 64'h1000_0003);
      chk("bp_req_ready", {63'h0, req_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_back_idle", {63'h0, req_ready}, 64'd1);

    // Back-to-back loads with req_valid held high.
    send(1'b0, 32'h0040_0004, '0, 32'h1000_0001, 1'b0, 1'b1, 1'b1);
    send(1'b0, 32'h1001_00FC, '0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
    send(1'b0, 32'h0040_0000, '0, 32'h1000_0000, 1'b0, 1'b1, 1'b0);
    n = 0;
    while ((sb_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end

    // Reset in the middle of a read: transaction dropped, no response afterwards.
    send(1'b0, 32'h0040_0010, '0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {63'h0, rsp_valid}, 64'd0);
    chk("mid_rst_req_ready", {63'h0, req_ready}, 64'd1);
    chk("mid_rst_rom_addr", {58'h0, rom_addr}, 64'd0);
    chk("mid_rst_rsp_rdata", {32'h0, rsp_rdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("mid_rst_no_rsp", {63'h0, saw_valid}, 64'd0);

    n = 0;
    while ((sb_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mu_access_ctrl.md
# mu_access_ctrl

Initiator side of the memory system: accepts one word-access request at a time from the multicycle datapath and drives the instruction ROM and data RAM. It decodes byte addresses into ROM or RAM word indices, sequences read latency and single-cycle writes, and returns the response through a valid/ready handshake. Bad accesses are flagged as errors, not forwarded to the memories.

## Interface
Parameters:
- DATA_WIDTH, 32, word width (from memory package)
- ADDR_WIDTH, 64, memory depth in words (from memory package)
- ROM_BASE, 32'h0040_0000, byte base address of ROM
- RAM_BASE, 32'h1001_0000, byte base address of RAM
- RD_LATENCY, 1, memory read latency in cycles (≥1)

Ports (IDX_W = $clog2(ADDR_WIDTH) = 6):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load/fetch
- req_addr  in  32  byte address
- req_wdata  in  DATA_WIDTH  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_WIDTH  load data (0 for stores and errors)
- rsp_err  out  1  access faulted
- rom_addr  out  IDX_W  ROM word index
- rom_rdata  in  inter_rom  ROM read data
- ram_addr  out  IDX_W  RAM word index
- ram_we  out  1  RAM write strobe
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  inter_ram  RAM read data

## Operation
- States: IDLE, RD_WAIT, WRITE, RESP.
- req_ready = 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready; address/data/we registered at acceptance.
- Decode (at acceptance): error if req_addr[1:0] ≠ 0; ROM hit if ROM_BASE ≤ addr < ROM_BASE+4·ADDR_WIDTH; RAM hit likewise with RAM_BASE; error if neither; error if store to ROM. Index = (addr − base) >> 2, truncated to IDX_W.
- IDLE → RD_WAIT on valid load; → WRITE on valid RAM store; → RESP (rsp_err=1) on error.
- RD_WAIT: counter loads RD_LATENCY−1, decrements; at 0 captures rom_rdata or ram_rdata (per region) into rsp_rdata, → RESP.
- WRITE: ram_we = 1 for exactly this one cycle with ram_addr/ram_wdata stable; → RESP.
- RESP: rsp_valid = 1, rsp_rdata/rsp_err held stable; → IDLE on rsp_ready. No new request accepted until then.
- rom_addr/ram_addr hold last driven index; ram_we is 0 outside WRITE; erroneous accesses never touch memory.

## Timing
- Reset (async, while rst_n = 0): state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, rom_addr 0, ram_addr 0, ram_we 0, ram_wdata 0, counter 0.
- Load accepted at edge N: rsp_valid high from cycle N+1+RD_LATENCY.
- Store accepted at edge N: ram_we high in cycle N+1, rsp_valid in N+2.
- Error accepted at edge N: rsp_valid with rsp_err in N+1.
- rsp_ready already high when rsp_valid rises: RESP lasts one cycle; earliest next acceptance one cycle after response.
- rsp_ready low: response held indefinitely, unchanged.
- Reset mid-operation: transaction dropped, ram_we drops immediately, no response issued.
- Address at top word (base+4·(ADDR_WIDTH−1)) valid; base+4·ADDR_WIDTH is an error (no wrap).

## Structure
- Add to the memory package: IDX_W constant, ROM_BASE/RAM_BASE constants, state enum typedef for the four states, region enum (REG_ROM, REG_RAM, REG_NONE).
- One sub-module: mu_addr_decode (combinational: byte address + we → region, index, error).

## Test plan
- Reset with rst_n = 0 mid-RD_WAIT → all outputs at reset values, no rsp_valid after release until new request.
- Load 0x0040_0008, ROM word 2 = 0x2008_0005, RD_LATENCY=1 → rom_addr=2, rsp_valid two cycles after acceptance, rsp_rdata=0x2008_0005, rsp_err=0.
- Store 0xDEAD_BEEF to 0x1001_00FC → ram_addr=63, ram_we high exactly one cycle; subsequent load of same address returns 0xDEAD_BEEF.
- Errors: load 0x1001_0002, load 0x1001_0100, store 0x0040_0000 → each rsp_err=1, rsp_rdata=0, ram_we never asserted.
- Backpressure: rsp_ready held low 5 cycles after load response → rsp_valid/rsp_rdata stable, req_ready 0 throughout; rsp_ready high → IDLE next cycle.
- Back-to-back: req_valid held high with three loads, rsp_ready tied high → each accepted only in IDLE, responses in order with correct data.
